// File: rtl/servant_ram_arbiter.sv
// servant_ram_arbiter
// Shares one single-port Wishbone RAM between the CPU instruction bus
// (read-only) and data bus (read/write). Each transaction is registered,
// issued to the RAM and its read data + ack are returned to the winner.
// Ties between the two masters are broken round-robin.
// Every output is driven from a flop, so there is no combinational path
// from any input to any output.
module servant_ram_arbiter #(
   parameter int aw = 10
) (
   input  logic          i_wb_clk,
   input  logic          i_wb_rst_n,
   // instruction bus (read-only)
   input  logic [aw-1:2] i_ibus_adr,
   input  logic          i_ibus_cyc,
   output logic [31:0]   o_ibus_rdt,
   output logic          o_ibus_ack,
   // data bus
   input  logic [aw-1:2] i_dbus_adr,
   input  logic [31:0]   i_dbus_dat,
   input  logic [3:0]    i_dbus_sel,
   input  logic          i_dbus_we,
   input  logic          i_dbus_cyc,
   output logic [31:0]   o_dbus_rdt,
   output logic          o_dbus_ack,
   // RAM side
   output logic [aw-1:2] o_ram_adr,
   output logic [31:0]   o_ram_dat,
   output logic [3:0]    o_ram_sel,
   output logic          o_ram_we,
   output logic          o_ram_cyc,
   input  logic [31:0]   i_ram_rdt,
   input  logic          i_ram_ack
);

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_ACCESS = 1'b1
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   // 1 when dbus was served last, so ibus wins the next tie (reset value)
   logic   r_last_dbus;
   // owner of the transaction currently at the RAM
   logic   r_win_dbus;

   logic   w_ibus_elig;
   logic   w_dbus_elig;
   logic   w_grant;
   logic   w_grant_dbus;
   logic   w_done;

   // A master still holds cyc during its ack cycle; that cycle must not
   // count as a fresh request or the same request would be served twice.
   assign w_ibus_elig = i_ibus_cyc & ~o_ibus_ack;
   assign w_dbus_elig = i_dbus_cyc & ~o_dbus_ack;

   // State register
   always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
      if (!i_wb_rst_n) r_state <= S_IDLE;
      else             r_state <= w_state_nxt;
   end

   // Next state, grant decision and completion strobe
   always_comb begin
      w_state_nxt  = r_state;
      w_grant      = 1'b0;
      w_grant_dbus = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_ibus_elig | w_dbus_elig) begin
               w_grant      = 1'b1;
               // dbus wins when alone, or on a tie when ibus went last
               w_grant_dbus = w_dbus_elig & (~w_ibus_elig | ~r_last_dbus);
               w_state_nxt  = S_ACCESS;
            end
         end
         S_ACCESS: begin
            // an ack seen in IDLE is stray and never reaches this branch
            if (i_ram_ack) begin
               w_done      = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Round-robin pointer and the owner of the in-flight transaction
   always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
      if (!i_wb_rst_n) begin
         r_last_dbus <= 1'b1;
         r_win_dbus  <= 1'b0;
      end else if (w_grant) begin
         r_last_dbus <= w_grant_dbus;
         r_win_dbus  <= w_grant_dbus;
      end
   end

   // RAM request: loaded on grant, held through ACCESS, dropped on ack
   always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
      if (!i_wb_rst_n) begin
         o_ram_adr <= '0;
         o_ram_dat <= '0;
         o_ram_sel <= '0;
         o_ram_we  <= 1'b0;
         o_ram_cyc <= 1'b0;
      end else if (w_grant) begin
         o_ram_cyc <= 1'b1;
         if (w_grant_dbus) begin
            o_ram_adr <= i_dbus_adr;
            o_ram_dat <= i_dbus_dat;
            o_ram_sel <= i_dbus_sel;
            o_ram_we  <= i_dbus_we;
         end else begin
            // ibus fetches are always full-word reads
            o_ram_adr <= i_ibus_adr;
            o_ram_dat <= '0;
            o_ram_sel <= 4'hf;
            o_ram_we  <= 1'b0;
         end
      end else if (w_done) begin
         o_ram_cyc <= 1'b0;
         o_ram_we  <= 1'b0;
      end
   end

   // Return path: one-cycle ack to the winner; rdt holds between acks
   always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
      if (!i_wb_rst_n) begin
         o_ibus_rdt <= '0;
         o_ibus_ack <= 1'b0;
         o_dbus_rdt <= '0;
         o_dbus_ack <= 1'b0;
      end else begin
         o_ibus_ack <= 1'b0;
         o_dbus_ack <= 1'b0;
         if (w_done) begin
            if (r_win_dbus) begin
               o_dbus_rdt <= i_ram_rdt;
               o_dbus_ack <= 1'b1;
            end else begin
               o_ibus_rdt <= i_ram_rdt;
               o_ibus_ack <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_servant_ram_arbiter.sv
// Bench for servant_ram_arbiter: a table of single transactions with
// hand-computed RAM-side and return values, hand-written sequences for
// contention, back-to-back requests and reset mid-access, then a short
// random phase checked against a reference memory.
module tb_servant_ram_arbiter;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:2] ibus_adr = '0;
   logic          ibus_cyc = 1'b0;
   logic [31:0]   ibus_rdt;
   logic          ibus_ack;
   logic [AW-1:2] dbus_adr = '0;
   logic [31:0]   dbus_dat = '0;
   logic [3:0]    dbus_sel = '0;
   logic          dbus_we = 1'b0;
   logic          dbus_cyc = 1'b0;
   logic [31:0]   dbus_rdt;
   logic          dbus_ack;
   logic [AW-1:2] ram_adr;
   logic [31:0]   ram_dat;
   logic [3:0]    ram_sel;
   logic          ram_we;
   logic          ram_cyc;
   logic [31:0]   ram_rdt;
   logic          ram_ack;

   logic          ram_ack_q = 1'b0;
   logic          force_ack = 1'b0;
   logic [31:0]   ram_rdt_q = '0;
   logic [31:0]   mem     [0:255];
   logic [31:0]   ref_mem [0:255];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   servant_ram_arbiter #(.aw(AW)) dut (
      .i_wb_clk  (clk),      .i_wb_rst_n(rst_n),
      .i_ibus_adr(ibus_adr), .i_ibus_cyc(ibus_cyc),
      .o_ibus_rdt(ibus_rdt), .o_ibus_ack(ibus_ack),
      .i_dbus_adr(dbus_adr), .i_dbus_dat(dbus_dat),
      .i_dbus_sel(dbus_sel), .i_dbus_we (dbus_we),
      .i_dbus_cyc(dbus_cyc), .o_dbus_rdt(dbus_rdt),
      .o_dbus_ack(dbus_ack),
      .o_ram_adr (ram_adr),  .o_ram_dat (ram_dat),
      .o_ram_sel (ram_sel),  .o_ram_we  (ram_we),
      .o_ram_cyc (ram_cyc),  .i_ram_rdt (ram_rdt),
      .i_ram_ack (ram_ack)
   );

   // RAM model: ack = cyc & !ack, byte-masked write, read of the old word
   assign ram_ack = ram_ack_q | force_ack;
   assign ram_rdt = ram_rdt_q;
   always @(posedge clk) begin
      ram_ack_q <= ram_cyc & ~ram_ack_q;
      if (ram_cyc & ~ram_ack_q) begin
         ram_rdt_q <= mem[ram_adr];
         if (ram_we)
            for (int b = 0; b < 4; b++)
               if (ram_sel[b]) mem[ram_adr][8*b +: 8] <= ram_dat[8*b +: 8];
      end
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 | i;
      mem[8'h10] <= 32'h1234_5678;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_ram_cyc"}, 32'(ram_cyc), 32'h0);
      chk({nm, "_ram_we"},  32'(ram_we),  32'h0);
      chk({nm, "_ram_sel"}, 32'(ram_sel), 32'h0);
      chk({nm, "_ram_adr"}, 32'(ram_adr), 32'h0);
      chk({nm, "_ram_dat"}, ram_dat,      32'h0);
      chk({nm, "_acks"},    {30'b0, ibus_ack, dbus_ack}, 32'h0);
      chk({nm, "_rdts"},    ibus_rdt | dbus_rdt, 32'h0);
   endtask

   typedef struct {
      logic        dbus;
      logic        we;
      logic [7:0]  adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic        chk_rdt;
      logic [31:0] exp_rdt;
      logic        exp_we;
      logic [3:0]  exp_sel;
      logic [31:0] exp_dat;
   } vec_t;

   // One transaction from idle: RAM request in cycle 1, ack in cycle 3
   task automatic run_vec(input vec_t v, input int idx);
      int     lat = 0;
      logic   other = 1'b0;
      logic [31:0] rdt = '0;
      string  nm = $sformatf("vec%0d", idx);
      @(negedge clk);
      if (v.dbus) begin
         dbus_adr = v.adr; dbus_dat = v.dat; dbus_sel = v.sel; dbus_we = v.we;
         dbus_cyc = 1'b1;
      end else begin
         // idle dbus carries junk that must not leak into an ibus access
         dbus_dat = 32'hFFFF_FFFF; dbus_sel = 4'h5; dbus_we = 1'b1;
         ibus_adr = v.adr; ibus_cyc = 1'b1;
      end
      for (int k = 1; k <= 8 && lat == 0; k++) begin
         @(posedge clk); #1;
         if (k == 1) begin
            chk({nm, "_ram_cyc"}, 32'(ram_cyc), 32'h1);
            chk({nm, "_ram_adr"}, 32'(ram_adr), 32'(v.adr));
            chk({nm, "_ram_we"},  32'(ram_we),  32'(v.exp_we));
            chk({nm, "_ram_sel"}, 32'(ram_sel), 32'(v.exp_sel));
            chk({nm, "_ram_dat"}, ram_dat,      v.exp_dat);
         end
         if (v.dbus ? ibus_ack : dbus_ack) other = 1'b1;
         if (v.dbus ? dbus_ack : ibus_ack) begin
            lat = k;
            rdt = v.dbus ? dbus_rdt : ibus_rdt;
            ibus_cyc = 1'b0; dbus_cyc = 1'b0;
         end
      end
      ibus_cyc = 1'b0; dbus_cyc = 1'b0;
      chk({nm, "_latency"}, 32'(lat), 32'd3);
      chk({nm, "_other_ack"}, 32'(other), 32'h0);
      if (v.chk_rdt) chk({nm, "_rdt"}, rdt, v.exp_rdt);
      @(posedge clk); #1;
      chk({nm, "_ack_pulse"}, {30'b0, ibus_ack, dbus_ack}, 32'h0);
   endtask

   vec_t vecs [10];

   initial begin
      int iw;
      int dw;

      //            dbus we  adr    dat            sel   chk  exp_rdt        we   sel   dat
      vecs[0] = '{1'b0, 1'b0, 8'h10, 32'h0,         4'h0, 1'b1, 32'h1234_5678, 1'b0, 4'hf, 32'h0};
      vecs[1] = '{1'b1, 1'b1, 8'h04, 32'hAABB_CCDD, 4'h3, 1'b0, 32'h0,         1'b1, 4'h3, 32'hAABB_CCDD};
      vecs[2] = '{1'b0, 1'b0, 8'h04, 32'h0,         4'h0, 1'b1, 32'h1000_CCDD, 1'b0, 4'hf, 32'h0};
      vecs[3] = '{1'b1, 1'b0, 8'h04, 32'h55AA_55AA, 4'hf, 1'b1, 32'h1000_CCDD, 1'b0, 4'hf, 32'h55AA_55AA};
      vecs[4] = '{1'b1, 1'b1, 8'h20, 32'h1122_3344, 4'h8, 1'b0, 32'h0,         1'b1, 4'h8, 32'h1122_3344};
      vecs[5] = '{1'b0, 1'b0, 8'h20, 32'h0,         4'h0, 1'b1, 32'h1100_0020, 1'b0, 4'hf, 32'h0};
      vecs[6] = '{1'b1, 1'b1, 8'hFF, 32'hDEAD_BEEF, 4'hf, 1'b0, 32'h0,         1'b1, 4'hf, 32'hDEAD_BEEF};
      vecs[7] = '{1'b0, 1'b0, 8'hFF, 32'h0,         4'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 4'hf, 32'h0};
      vecs[8] = '{1'b0, 1'b0, 8'h00, 32'h0,         4'h0, 1'b1, 32'h1000_0000, 1'b0, 4'hf, 32'h0};
      vecs[9] = '{1'b1, 1'b0, 8'hFF, 32'h0,         4'h2, 1'b1, 32'hDEAD_BEEF, 1'b0, 4'h2, 32'h0};

      for (int i = 0; i < 256; i++) ref_mem[i] = 32'h1000_0000 | i;
      ref_mem[8'h10] = 32'h1234_5678;

      // reset state
      repeat (2) @(posedge clk);
      #1 chk_all_zero("reset");

      // both masters request from reset and hold: ibus, dbus, ibus, dbus
      @(negedge clk);
      rst_n = 1'b1;
      ibus_adr = 8'h10; ibus_cyc = 1'b1;
      dbus_adr = 8'h20; dbus_sel = 4'hf; dbus_we = 1'b0; dbus_dat = '0; dbus_cyc = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         chk($sformatf("rr_ibus_ack_c%0d", k), 32'(ibus_ack), 32'(k == 3 || k == 9));
         chk($sformatf("rr_dbus_ack_c%0d", k), 32'(dbus_ack), 32'(k == 6 || k == 12));
         if (ibus_ack) chk("rr_ibus_rdt", ibus_rdt, 32'h1234_5678);
         if (dbus_ack) chk("rr_dbus_rdt", dbus_rdt, 32'h1000_0020);
      end
      ibus_cyc = 1'b0; dbus_cyc = 1'b0;
      repeat (5) @(posedge clk);

      // ibus alone, held high: one ack per 4 cycles, never back-to-back
      @(negedge clk);
      ibus_adr = 8'h10; ibus_cyc = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         @(posedge clk); #1;
         chk($sformatf("hold_ibus_ack_c%0d", k), 32'(ibus_ack), 32'(k % 4 == 3));
      end
      ibus_cyc = 1'b0;
      repeat (4) @(posedge clk);

      // reset during ACCESS, then a stray RAM ack in IDLE
      @(negedge clk);
      ibus_adr = 8'h10; ibus_cyc = 1'b1;
      @(posedge clk); #1;
      chk("midrst_ram_cyc_before", 32'(ram_cyc), 32'h1);
      rst_n = 1'b0; ibus_cyc = 1'b0;
      #1 chk_all_zero("midrst");
      @(negedge clk);
      rst_n = 1'b1; force_ack = 1'b1;
      @(negedge clk);
      force_ack = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         chk($sformatf("stray_acks_c%0d", k), {30'b0, ibus_ack, dbus_ack}, 32'h0);
         chk($sformatf("stray_ram_cyc_c%0d", k), 32'(ram_cyc), 32'h0);
      end

      // single-transaction table
      for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

      // random traffic against the reference memory
      ref_mem[8'h04] = 32'h1000_CCDD;
      ref_mem[8'h20] = 32'h1100_0020;
      ref_mem[8'hFF] = 32'hDEAD_BEEF;
      iw = 0; dw = 0;
      for (int c = 0; c < 400; c++) begin
         @(posedge clk); #1;
         if (ibus_cyc) begin
            iw++;
            if (ibus_ack) begin
               chk("rnd_ibus_rdt", ibus_rdt, ref_mem[ibus_adr]);
               chk("rnd_ibus_wait", 32'(iw <= 7), 32'h1);
               ibus_cyc = 1'b0;
            end else if (iw > 20) begin
               $display("FAIL rnd_ibus_timeout: waited %0d cycles, limit 7", iw);
               $fatal(1);
            end
         end else if ($urandom_range(1, 0) == 1) begin
            ibus_adr = 8'h40 + 8'($urandom_range(15, 0));
            ibus_cyc = 1'b1; iw = 0;
         end
         if (dbus_cyc) begin
            dw++;
            if (dbus_ack) begin
               if (dbus_we) begin
                  for (int b = 0; b < 4; b++)
                     if (dbus_sel[b]) ref_mem[dbus_adr][8*b +: 8] = dbus_dat[8*b +: 8];
               end else begin
                  chk("rnd_dbus_rdt", dbus_rdt, ref_mem[dbus_adr]);
               end
               chk("rnd_dbus_wait", 32'(dw <= 7), 32'h1);
               dbus_cyc = 1'b0;
            end else if (dw > 20) begin
               $display("FAIL rnd_dbus_timeout: waited %0d cycles, limit 7", dw);
               $fatal(1);
            end
         end else if ($urandom_range(1, 0) == 1) begin
            dbus_adr = 8'h40 + 8'($urandom_range(15, 0));
            dbus_we  = 1'($urandom_range(1, 0));
            dbus_dat = $urandom;
            dbus_sel = dbus_we ? 4'($urandom_range(15, 1)) : 4'hf;
            dbus_cyc = 1'b1; dw = 0;
         end
      end
      ibus_cyc = 1'b0; dbus_cyc = 1'b0;
      repeat (8) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
